// File: rtl/axi_ic_pkg.sv
// Shared types and width helpers for the AXI interconnect write-data path.
package axi_ic_pkg;

    localparam int unsigned WBusWidthDefault = 128;

    // A count of one still needs a one-bit index so ports never collapse to zero width.
    function automatic int unsigned grant_width(input int unsigned num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    function automatic int unsigned slave_idx_width(input int unsigned num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

    typedef struct packed {
        logic                            wlast;
        logic [WBusWidthDefault/8-1:0]   wstrb;
        logic [WBusWidthDefault-1:0]     wdata;
    } w_beat_t;

endpackage

// File: rtl/axi_w_if.sv
// AXI W channel bundle with master/slave modports.
// valid/ready: a beat transfers on a rising edge where wvalid and wready are both high;
// once wvalid is raised the payload is held stable until that transfer.
interface axi_w_if #(
    parameter int unsigned AxiBusWidth = 128
);
    logic                     wvalid;
    logic                     wready;
    logic [AxiBusWidth-1:0]   wdata;
    logic [AxiBusWidth/8-1:0] wstrb;
    logic                     wlast;

    modport master (output wvalid, wdata, wstrb, wlast, input wready);
    modport slave  (input wvalid, wdata, wstrb, wlast, output wready);
endinterface

// File: rtl/axi_ic_order_fifo.sv
// Ordering queue: synchronous FIFO with registered head, occupancy count and full/empty flags.
module axi_ic_order_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntWidth = $clog2(Depth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    head_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [CntWidth-1:0] count_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntWidth'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot, so a push into a full queue is kept when it coincides with a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry skid buffer with registered ready; only built when AXI_IC_W_SKID_EN is defined.
`ifdef AXI_IC_W_SKID_EN
module pipeline_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i
);
    logic             out_valid_q, skid_valid_q;
    logic [Width-1:0] out_data_q, skid_data_q;

    assign ready_o = !skid_valid_q;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;

    // The skid slot only fills when the output register is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= valid_i;
                out_data_q  <= data_i;
            end
        end else if (valid_i && !skid_valid_q) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= data_i;
        end
    end

endmodule
`endif

// File: rtl/axi_ic_w_ordered.sv
// W router: forwards each master's beats to the slave whose AW it won, in AW-acceptance order.
// Optional slave-side skid stage selected with AXI_IC_W_SKID_EN.
module axi_ic_w_ordered
    import axi_ic_pkg::*;
#(
    parameter int unsigned NumMasters  = 2,
    parameter int unsigned NumSlaves   = 2,
    parameter int unsigned AxiBusWidth = 128,
    parameter int unsigned OrderDepth  = 4,
    localparam int unsigned GrantWidth = grant_width(NumMasters)
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    input  logic [NumSlaves-1:0]  aw_accept_i,
    input  logic [GrantWidth-1:0] aw_master_i [NumSlaves],
    output logic [NumSlaves-1:0]  aw_stall_o,
    output logic [NumMasters-1:0] aw_stall_m_o,
    axi_w_if.slave                axi_sl_w [NumMasters],
    axi_w_if.master               axi_m_w [NumSlaves],
    output logic [NumSlaves-1:0]  wlast_o
);
    localparam int unsigned SlvWidth = slave_idx_width(NumSlaves);
    localparam int unsigned CntWidth = $clog2(OrderDepth) + 1;

    typedef struct packed {
        logic                     wlast;
        logic [AxiBusWidth/8-1:0] wstrb;
        logic [AxiBusWidth-1:0]   wdata;
    } beat_t;

    logic [NumSlaves-1:0]  sq_push, sq_pop;
    logic [GrantWidth-1:0] sq_head [NumSlaves];
    logic                  sq_empty [NumSlaves];
    logic                  sq_full [NumSlaves];
    logic [CntWidth-1:0]   sq_count [NumSlaves];

    logic [NumMasters-1:0] mq_push, mq_pop;
    logic [SlvWidth-1:0]   mq_wdata [NumMasters];
    logic [SlvWidth-1:0]   mq_head [NumMasters];
    logic                  mq_empty [NumMasters];
    logic                  mq_full [NumMasters];
    logic [CntWidth-1:0]   mq_count [NumMasters];

    logic                  m_wvalid [NumMasters];
    beat_t                 m_beat [NumMasters];
    logic [NumMasters-1:0] m_wready;
    logic [NumSlaves-1:0]  path_open [NumMasters];

    logic [NumSlaves-1:0]  route_valid;
    beat_t                 route_beat [NumSlaves];
    logic                  route_ready [NumSlaves];
    logic                  out_valid [NumSlaves];
    beat_t                 out_beat [NumSlaves];
    logic                  out_ready [NumSlaves];

    for (genvar m = 0; m < NumMasters; m++) begin : g_master
        assign m_wvalid[m]       = axi_sl_w[m].wvalid;
        assign m_beat[m].wdata   = axi_sl_w[m].wdata;
        assign m_beat[m].wstrb   = axi_sl_w[m].wstrb;
        assign m_beat[m].wlast   = axi_sl_w[m].wlast;
        assign axi_sl_w[m].wready = m_wready[m];

        axi_ic_order_fifo #(.Width(SlvWidth), .Depth(OrderDepth)) u_mq (
            .clk_i  (aclk),
            .rst_ni (rst_n),
            .push_i (mq_push[m]),
            .data_i (mq_wdata[m]),
            .pop_i  (mq_pop[m]),
            .head_o (mq_head[m]),
            .empty_o(mq_empty[m]),
            .full_o (mq_full[m]),
            .count_o(mq_count[m])
        );

        assert property (@(posedge aclk) disable iff (!rst_n)
            !(mq_push[m] && mq_full[m] && !mq_pop[m]));
    end

    for (genvar s = 0; s < NumSlaves; s++) begin : g_slave
        axi_ic_order_fifo #(.Width(GrantWidth), .Depth(OrderDepth)) u_sq (
            .clk_i  (aclk),
            .rst_ni (rst_n),
            .push_i (sq_push[s]),
            .data_i (aw_master_i[s]),
            .pop_i  (sq_pop[s]),
            .head_o (sq_head[s]),
            .empty_o(sq_empty[s]),
            .full_o (sq_full[s]),
            .count_o(sq_count[s])
        );

        assert property (@(posedge aclk) disable iff (!rst_n)
            !(sq_push[s] && sq_full[s] && !sq_pop[s]));

`ifdef AXI_IC_W_SKID_EN
        pipeline_skid_buffer #(.Width($bits(beat_t))) u_skid (
            .clk_i  (aclk),
            .rst_ni (rst_n),
            .valid_i(route_valid[s]),
            .data_i (route_beat[s]),
            .ready_o(route_ready[s]),
            .valid_o(out_valid[s]),
            .data_o (out_beat[s]),
            .ready_i(out_ready[s])
        );
`else
        assign out_valid[s]   = route_valid[s];
        assign out_beat[s]    = route_beat[s];
        assign route_ready[s] = out_ready[s];
`endif

        assign axi_m_w[s].wvalid = out_valid[s];
        assign axi_m_w[s].wdata  = out_beat[s].wdata;
        assign axi_m_w[s].wstrb  = out_beat[s].wstrb;
        assign axi_m_w[s].wlast  = out_beat[s].wlast;
        assign out_ready[s]      = axi_m_w[s].wready;
    end

    // Each accepted AW pushes the owning master into its slave's queue and vice versa.
    always_comb begin
        sq_push = aw_accept_i;
        mq_push = '0;
        for (int m = 0; m < NumMasters; m++) begin
            mq_wdata[m] = '0;
            for (int s = 0; s < NumSlaves; s++) begin
                if (aw_accept_i[s] && (aw_master_i[s] == GrantWidth'(m))) begin
                    mq_push[m]  = 1'b1;
                    mq_wdata[m] = SlvWidth'(s);
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NumMasters; m++) begin
            for (int s = 0; s < NumSlaves; s++) begin
                path_open[m][s] = !mq_empty[m] && !sq_empty[s] &&
                                  (mq_head[m] == SlvWidth'(s)) &&
                                  (sq_head[s] == GrantWidth'(m));
            end
        end
    end

    // Matching queue heads make at most one open path per master and per slave.
    always_comb begin
        route_valid = '0;
        m_wready    = '0;
        mq_pop      = '0;
        sq_pop      = '0;
        for (int s = 0; s < NumSlaves; s++) route_beat[s] = '0;
        for (int m = 0; m < NumMasters; m++) begin
            for (int s = 0; s < NumSlaves; s++) begin
                if (path_open[m][s]) begin
                    route_valid[s] = m_wvalid[m];
                    route_beat[s]  = m_beat[m];
                    m_wready[m]    = route_ready[s];
                    if (m_wvalid[m] && route_ready[s] && m_beat[m].wlast) begin
                        mq_pop[m] = 1'b1;
                        sq_pop[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NumSlaves; s++) begin
            aw_stall_o[s] = (sq_count[s] == CntWidth'(OrderDepth));
            wlast_o[s]    = out_valid[s] && out_ready[s] && out_beat[s].wlast;
        end
        for (int m = 0; m < NumMasters; m++) begin
            aw_stall_m_o[m] = (mq_count[m] == CntWidth'(OrderDepth));
        end
    end

endmodule

// File: tb/tb_axi_ic_w_ordered.sv
// Directed bench for axi_ic_w_ordered (default build: no skid stage, zero-latency data path).
module tb_axi_ic_w_ordered;

    logic       aclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] aw_accept_i;
    logic [0:0] aw_master_i [2];
    logic [1:0] aw_stall_o;
    logic [1:0] aw_stall_m_o;
    logic [1:0] wlast_o;

    axi_w_if #(.AxiBusWidth(128)) sl_w [2] ();
    axi_w_if #(.AxiBusWidth(128)) m_w [2] ();

    axi_ic_w_ordered #(
        .NumMasters (2),
        .NumSlaves  (2),
        .AxiBusWidth(128),
        .OrderDepth (4)
    ) dut (
        .aclk        (aclk),
        .rst_n       (rst_n),
        .aw_accept_i (aw_accept_i),
        .aw_master_i (aw_master_i),
        .aw_stall_o  (aw_stall_o),
        .aw_stall_m_o(aw_stall_m_o),
        .axi_sl_w    (sl_w),
        .axi_m_w     (m_w),
        .wlast_o     (wlast_o)
    );

    always #5 aclk = ~aclk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] exp_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [127:0] obs);
        logic [127:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check(tag, obs, exp);
    endtask

    task automatic drive_m(input int m, input logic v, input logic [127:0] d, input logic l);
        if (m == 0) begin
            sl_w[0].wvalid = v; sl_w[0].wdata = d; sl_w[0].wstrb = d[15:0]; sl_w[0].wlast = l;
        end else begin
            sl_w[1].wvalid = v; sl_w[1].wdata = d; sl_w[1].wstrb = d[15:0]; sl_w[1].wlast = l;
        end
    endtask

    task automatic aw(input int s, input int m, input logic en);
        aw_accept_i[s] = en;
        aw_master_i[s] = 1'(m);
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        aw_accept_i    = '0;
        aw_master_i[0] = '0;
        aw_master_i[1] = '0;
        drive_m(0, 1'b0, '0, 1'b0);
        drive_m(1, 1'b1, 128'h55, 1'b1);
        m_w[0].wready = 1'b1;
        m_w[1].wready = 1'b1;

        // Reset values
        #12;
        check("rst_s0_wvalid", m_w[0].wvalid, 0);
        check("rst_s1_wvalid", m_w[1].wvalid, 0);
        check("rst_m0_wready", sl_w[0].wready, 0);
        check("rst_m1_wready", sl_w[1].wready, 0);
        check("rst_aw_stall", aw_stall_o, 0);
        check("rst_aw_stall_m", aw_stall_m_o, 0);
        check("rst_wlast_o", wlast_o, 0);
        tick(); rst_n = 1'b1; drive_m(1, 1'b0, '0, 1'b0);

        // Single burst m0 -> s1, with one backpressure cycle
        tick(); aw(1, 0, 1'b1); drive_m(0, 1'b1, 128'hA0, 1'b0); settle();
        check("t1_no_bypass_wready", sl_w[0].wready, 0);
        check("t1_no_bypass_wvalid", m_w[1].wvalid, 0);
        check("t1_idle_wdata_zero", m_w[1].wdata, 0);
        for (int b = 0; b < 4; b++) exp_q.push_back(128'hA0 + 128'(b));
        for (int b = 0; b < 4; b++) begin
            tick(); aw(1, 0, 1'b0); drive_m(0, 1'b1, 128'hA0 + 128'(b), b == 3);
            if (b == 1) begin
                m_w[1].wready = 1'b0; settle();
                check("t1_bp_wready", sl_w[0].wready, 0);
                check("t1_bp_wlast_o", wlast_o, 0);
                tick(); m_w[1].wready = 1'b1;
            end
            settle();
            check("t1_s1_wvalid", m_w[1].wvalid, 1);
            check_data("t1_s1_wdata", m_w[1].wdata);
            check("t1_s1_wlast", m_w[1].wlast, 1'(b == 3));
            check("t1_wlast_o", wlast_o, (b == 3) ? 2'b10 : 2'b00);
            check("t1_m0_wready", sl_w[0].wready, 1);
            check("t1_s0_quiet", m_w[0].wvalid, 0);
            if (b == 0) check("t1_s1_wstrb", m_w[1].wstrb, 16'h00A0);
        end
        tick(); drive_m(0, 1'b1, 128'hEE, 1'b1); settle();
        check("t1_path_closed_wready", sl_w[0].wready, 0);
        check("t1_path_closed_wvalid", m_w[1].wvalid, 0);
        check("t1_path_closed_wlast_o", wlast_o, 0);
        tick(); drive_m(0, 1'b0, '0, 1'b0);

        // W before AW: m1 -> s0
        for (int i = 0; i < 3; i++) begin
            tick(); drive_m(1, 1'b1, 128'hB0, 1'b0); settle();
            check("t2_early_wready", sl_w[1].wready, 0);
            check("t2_early_wvalid", m_w[0].wvalid, 0);
        end
        tick(); aw(0, 1, 1'b1); settle();
        check("t2_accept_cycle_wready", sl_w[1].wready, 0);
        exp_q.push_back(128'hB0);
        exp_q.push_back(128'hB1);
        tick(); aw(0, 0, 1'b0); settle();
        check("t2_b0_wready", sl_w[1].wready, 1);
        check_data("t2_b0_wdata", m_w[0].wdata);
        tick(); drive_m(1, 1'b1, 128'hB1, 1'b1); settle();
        check_data("t2_b1_wdata", m_w[0].wdata);
        check("t2_wlast_o", wlast_o, 2'b01);
        tick(); drive_m(1, 1'b0, '0, 1'b0);

        // Ordering: m0 -> s0 then m1 -> s0
        tick(); aw(0, 0, 1'b1);
        tick(); aw(0, 1, 1'b1); settle();
        check("t3_no_stall", aw_stall_o, 0);
        exp_q.push_back(128'hC0); exp_q.push_back(128'hC1);
        exp_q.push_back(128'hD0); exp_q.push_back(128'hD1);
        tick(); aw(0, 0, 1'b0); drive_m(0, 1'b1, 128'hC0, 1'b0); drive_m(1, 1'b1, 128'hD0, 1'b0); settle();
        check_data("t3_c0_wdata", m_w[0].wdata);
        check("t3_m0_wready", sl_w[0].wready, 1);
        check("t3_m1_blocked_0", sl_w[1].wready, 0);
        tick(); drive_m(0, 1'b1, 128'hC1, 1'b1); settle();
        check_data("t3_c1_wdata", m_w[0].wdata);
        check("t3_m1_blocked_1", sl_w[1].wready, 0);
        check("t3_c_wlast_o", wlast_o, 2'b01);
        tick(); drive_m(0, 1'b0, '0, 1'b0); settle();
        check_data("t3_d0_wdata", m_w[0].wdata);
        check("t3_m1_wready", sl_w[1].wready, 1);
        check("t3_m0_done", sl_w[0].wready, 0);
        tick(); drive_m(1, 1'b1, 128'hD1, 1'b1); settle();
        check_data("t3_d1_wdata", m_w[0].wdata);
        check("t3_d_wlast_o", wlast_o, 2'b01);
        tick(); drive_m(1, 1'b0, '0, 1'b0);

        // Full queue, then simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            tick(); aw(0, 0, 1'b1); settle();
            check("t4_stall_before_full", aw_stall_o, 0);
        end
        tick(); aw(0, 0, 1'b0); settle();
        check("t4_full_stall_s", aw_stall_o, 2'b01);
        check("t4_full_stall_m", aw_stall_m_o, 2'b01);
        tick(); aw(0, 0, 1'b1); drive_m(0, 1'b1, 128'hE0, 1'b1); settle();
        check("t4_pp_wready", sl_w[0].wready, 1);
        check("t4_pp_wlast_o", wlast_o, 2'b01);
        check("t4_pp_stall_s", aw_stall_o, 2'b01);
        tick(); aw(0, 0, 1'b0); drive_m(0, 1'b0, '0, 1'b0); settle();
        check("t4_after_pp_stall_s", aw_stall_o, 2'b01);
        check("t4_after_pp_stall_m", aw_stall_m_o, 2'b01);
        tick(); drive_m(0, 1'b1, 128'hE1, 1'b1); settle();
        check("t4_pop_cycle_stall_s", aw_stall_o, 2'b01);
        check("t4_pop_wlast_o", wlast_o, 2'b01);
        tick(); drive_m(0, 1'b0, '0, 1'b0); settle();
        check("t4_released_stall_s", aw_stall_o, 0);
        check("t4_released_stall_m", aw_stall_m_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); drive_m(0, 1'b1, 128'hE2 + 128'(i), 1'b1); settle();
            check("t4_drain_wready", sl_w[0].wready, 1);
        end
        tick(); drive_m(0, 1'b1, 128'hFF, 1'b1); settle();
        check("t4_drained_wready", sl_w[0].wready, 0);
        tick(); drive_m(0, 1'b0, '0, 1'b0);

        // Reset in the middle of a burst
        tick(); aw(1, 0, 1'b1);
        tick(); aw(1, 0, 1'b0); drive_m(0, 1'b1, 128'hF0, 1'b0); settle();
        check("t5_beat1_wvalid", m_w[1].wvalid, 1);
        tick(); drive_m(0, 1'b1, 128'hF1, 1'b0); settle();
        check("t5_beat2_wvalid", m_w[1].wvalid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_s1_wvalid", m_w[1].wvalid, 0);
        check("t5_rst_m0_wready", sl_w[0].wready, 0);
        tick(); rst_n = 1'b1; settle();
        check("t5_post_rst_wready", sl_w[0].wready, 0);
        check("t5_post_rst_wvalid", m_w[1].wvalid, 0);
        check("t5_post_rst_stall", aw_stall_m_o, 0);
        tick(); drive_m(0, 1'b0, '0, 1'b0); aw(1, 1, 1'b1); drive_m(1, 1'b1, 128'h60, 1'b1); settle();
        check("t5_new_accept_wready", sl_w[1].wready, 0);
        exp_q.push_back(128'h60);
        tick(); aw(1, 0, 1'b0); settle();
        check("t5_new_wready", sl_w[1].wready, 1);
        check_data("t5_new_wdata", m_w[1].wdata);
        check("t5_new_wlast_o", wlast_o, 2'b10);
        tick(); drive_m(1, 1'b0, '0, 1'b0); settle();
        check("t5_idle_wvalid", m_w[1].wvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
